// File: rtl/dma_src_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_src_memory_if
// Description : AXI4-Lite read channel (AR/R) between the DMA master and
//               its source memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_src_memory_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/dma_src_memory.sv
`default_nettype none
// ============================================================================
// Module      : dma_src_memory
// Description : AXI4-Lite read-only source memory with programmable wait
//               states and a synchronous preload port. Define SRC_PATTERN_EN
//               to replace the array with an address-derived data pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_src_memory #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  wire logic                  aclk,
    input  wire logic                  areset,
    dma_src_memory_if.slave            s_axi,
    input  wire logic                  load_en,
    input  wire logic [ADDR_WIDTH-1:0] load_addr,
    input  wire logic [31:0]           load_data,
    output logic [15:0]                rd_count
);

    localparam int         c_depth     = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_wait_cnt;
    logic [31:0]           r_addr;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic [15:0]           r_rd_count;

    logic [31:0]           w_offset;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rdata;

    // BASE_ADDR is aligned, so offset[1:0] equals araddr[1:0]; the upper
    // bits catch both overrun and the wrap of an address below the base.
    assign w_offset = r_addr - BASE_ADDR;
    assign w_err    = (w_offset[1:0] != 2'b00) || (w_offset[31:ADDR_WIDTH+2] != '0);

`ifdef SRC_PATTERN_EN
    logic w_unused_load;
    assign w_unused_load = ^{load_en, load_addr, load_data, w_offset[ADDR_WIDTH+1:2]};
    assign w_rdata       = DATA_WIDTH'(r_addr ^ 32'hA5A5_A5A5);
`else
    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    always_ff @(posedge aclk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign w_rdata = r_mem[w_offset[ADDR_WIDTH+1:2]];
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= c_idle;
            r_wait_cnt <= 4'd0;
            r_addr     <= 32'd0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
            r_rd_count <= 16'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_arready <= 1'b1;
                    if (s_axi.arvalid && r_arready) begin
                        r_arready  <= 1'b0;
                        r_addr     <= s_axi.araddr;
                        r_wait_cnt <= c_wait_init;
                        r_state    <= (WAIT_CYCLES == 0) ? c_resp : c_wait;
                    end
                end
                c_wait: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_state <= c_resp;
                    end
                end
                c_resp: begin
                    // First RESP cycle captures the response; a load on the
                    // same edge lands after the read (read-before-write).
                    if (!r_rvalid) begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= w_err ? 2'b10 : 2'b00;
                        r_rdata  <= w_err ? '0 : w_rdata;
                    end else if (s_axi.rready) begin
                        r_rvalid   <= 1'b0;
                        r_rd_count <= r_rd_count + 16'd1;
                        r_arready  <= 1'b1;
                        r_state    <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;
    assign rd_count      = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_dma_src_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_src_memory
// Description : Self-checking bench for dma_src_memory with a behavioural
//               reference memory and randomized reads/loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_src_memory;

    localparam int          AW     = 10;
    localparam int          DEPTH  = 1 << AW;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          WAIT_C = 2;
    localparam int          TMO    = 40;

    logic            clk;
    logic            areset;
    logic            load_en;
    logic [AW-1:0]   load_addr;
    logic [31:0]     load_data;
    logic [15:0]     rd_count;

    dma_src_memory_if #(.DATA_WIDTH(32)) bus ();

    dma_src_memory #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (32),
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAIT_C)
    ) dut (
        .aclk      (clk),
        .areset    (areset),
        .s_axi     (bus.slave),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_count  (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [DEPTH];
    int          ref_count = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {rresp, rdata} expected for a read of byte address a
    function automatic logic [33:0] model(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if ((a % 4) != 0 || off >= 32'(4 * DEPTH))
            return {2'b10, 32'h0};
`ifdef SRC_PATTERN_EN
        return {2'b00, a ^ 32'hA5A5_A5A5};
`else
        return {2'b00, ref_mem[off / 4]};
`endif
    endfunction

    // All tasks start and end at a falling edge.
    task automatic load_word(input int idx, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = AW'(idx);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall, input bit collide,
                           input int cidx, input logic [31:0] cdata,
                           output logic [31:0] obs);
        logic [33:0] exp;
        int t;
        int e;
        exp = model(a);
        obs = 32'hx;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        t = 0;
        while (bus.arready !== 1'b1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("ar_accept", 64'(bus.arready), 64'd1);
        if (bus.arready !== 1'b1) begin
            bus.arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        chk("arready_low_after_ar", 64'(bus.arready), 64'd0);
        e = 0;
        while (bus.rvalid !== 1'b1 && e < TMO) begin
            if (collide && e == WAIT_C) begin
                load_en   = 1'b1;
                load_addr = AW'(cidx);
                load_data = cdata;
            end
            @(negedge clk);
            load_en = 1'b0;
            e++;
        end
        if (collide) ref_mem[cidx] = cdata;
        chk("rvalid_latency", 64'(e), 64'(WAIT_C + 1));
        if (bus.rvalid !== 1'b1) return;
        obs = bus.rdata;
        chk("rdata", 64'(bus.rdata), 64'(exp[31:0]));
        chk("rresp", 64'(bus.rresp), 64'(exp[33:32]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_rvalid", 64'(bus.rvalid), 64'd1);
            chk("stall_rdata", 64'(bus.rdata), 64'(exp[31:0]));
            chk("stall_arready", 64'(bus.arready), 64'd0);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        ref_count++;
        chk("rvalid_drop", 64'(bus.rvalid), 64'd0);
        chk("arready_back", 64'(bus.arready), 64'd1);
        chk("rd_count", 64'(rd_count), 64'(16'(ref_count)));
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        int          sel;
        int          e;

        areset      = 1'b1;
        bus.araddr  = 32'h0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = 32'h0;
        #1;
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_rresp", 64'(bus.rresp), 64'd0);
        chk("rst_rd_count", 64'(rd_count), 64'd0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        chk("arready_after_rst", 64'(bus.arready), 64'd1);

        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);

        // Directed: first four words
        load_word(0, 32'h11);
        load_word(1, 32'h22);
        load_word(2, 32'h33);
        load_word(3, 32'h44);
        for (int i = 0; i < 4; i++) do_read(32'(i * 4), 0, 1'b0, 0, 32'h0, obs);
        chk("rd_count_four", 64'(rd_count), 64'd4);

        // Decode errors
        do_read(32'h0000_0002, 0, 1'b0, 0, 32'h0, obs);
        do_read(32'h0000_1000, 0, 1'b0, 0, 32'h0, obs);

        // Back-pressure
        do_read(32'h0000_0008, 5, 1'b0, 0, 32'h0, obs);

        // Load colliding with response capture
        load_word(5, 32'hBEEF);
        do_read(32'h0000_0014, 0, 1'b1, 5, 32'hDEAD, obs);
        do_read(32'h0000_0014, 0, 1'b0, 0, 32'h0, obs);

        do_read(32'h0000_0010, 0, 1'b0, 0, 32'h0, obs);
`ifdef SRC_PATTERN_EN
        chk("pattern_0x10", 64'(obs), 64'h0000_0000_A5A5_A5B5);
`endif

        // Randomized loads and reads
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) load_word(int'($urandom_range(0, DEPTH - 1)), $urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)
                a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (sel < 8)
                a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else
                a = $urandom | 32'h0000_1000;
            do_read(a, int'($urandom_range(0, 3)), 1'b0, 0, 32'h0, obs);
        end

        // Reset during WAIT
        bus.araddr  = 32'h0000_0004;
        bus.arvalid = 1'b1;
        e = 0;
        while (bus.arready !== 1'b1 && e < TMO) begin
            @(negedge clk);
            e++;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        @(negedge clk);
        areset = 1'b1;
        #1;
        chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("midrst_arready", 64'(bus.arready), 64'd0);
        chk("midrst_rd_count", 64'(rd_count), 64'd0);
        ref_count = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_rvalid", 64'(bus.rvalid), 64'd0);
        end
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_rvalid", 64'(bus.rvalid), 64'd0);
        end
        do_read(32'h0000_0004, 0, 1'b0, 0, 32'h0, obs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
